// File: rtl/add_pkg.sv
// Shared definitions for the pipelined add/subtract datapath.
package add_pkg;

  // Operation select carried on the op input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage : add_pkg

// File: rtl/add_sub_pipe_slice.sv
// Combinational ripple-carry adder for one slice of the pipelined adder.
module adder_slice #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [WIDTH:0] c;

  // Chain of 1-bit full adders, carry rippling from bit 0 upward.
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[WIDTH];
  end

endmodule : adder_slice

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract: one WIDTH/STAGES-bit slice per stage, carry
// registered between stages, valid/ready handshake on both sides.
module add_sub_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("add_sub_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  // Subtract is A + ~B + 1; the +1 enters as the stage-0 carry.
  logic [WIDTH-1:0] bx;
  logic             cin0;
  assign bx   = (op == OP_ADD) ? B : ~B;
  assign cin0 = (op == OP_SUB);

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] rdy;

  // Stage k may load when it is empty or its content moves on this cycle.
  always_comb begin
    rdy       = '0;
    rdy[LAST] = !vld_p[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      rdy[k] = !vld_p[k] || rdy[k + 1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_p[LAST];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int DONE_W = (k + 1) * SW;   // result bits complete after this stage
    localparam int UP_W   = WIDTH - DONE_W; // operand bits still to be added

    logic              vld_q;
    logic              carry_q;
    logic [DONE_W-1:0] sum_q;
    logic              vsrc;
    logic              cin;
    logic [SW-1:0]     a_sl;
    logic [SW-1:0]     b_sl;
    logic [SW-1:0]     s_sl;
    logic              c_sl;
    logic [DONE_W-1:0] sum_d;

    if (k == 0) begin : g_src
      assign vsrc  = in_valid;
      assign cin   = cin0;
      assign a_sl  = A[SW-1:0];
      assign b_sl  = bx[SW-1:0];
      assign sum_d = s_sl;
    end else begin : g_src
      assign vsrc  = g_st[k-1].vld_q;
      assign cin   = g_st[k-1].carry_q;
      assign a_sl  = g_st[k-1].g_up.a_q[SW-1:0];
      assign b_sl  = g_st[k-1].g_up.b_q[SW-1:0];
      assign sum_d = {s_sl, g_st[k-1].sum_q};
    end

    adder_slice #(
      .WIDTH(SW)
    ) u_slice (
      .sum (s_sl),
      .cout(c_sl),
      .a   (a_sl),
      .b   (b_sl),
      .cin (cin)
    );

    // ---- stage k register boundary ----
    // Valid bit: the only state cleared by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
      end else if (rdy[k]) begin
        vld_q <= vsrc;
      end
    end

    assign vld_p[k] = vld_q;

    // Completed low sum slices and the carry into the next slice.
    always_ff @(posedge clk) begin
      if (rdy[k]) begin
        carry_q <= c_sl;
        sum_q   <= sum_d;
      end
    end

    if (UP_W > 0) begin : g_up
      logic [UP_W-1:0] a_q;
      logic [UP_W-1:0] b_q;
      logic [UP_W-1:0] a_up;
      logic [UP_W-1:0] b_up;

      if (k == 0) begin : g_usrc
        assign a_up = A[WIDTH-1:SW];
        assign b_up = bx[WIDTH-1:SW];
      end else begin : g_usrc
        assign a_up = g_st[k-1].g_up.a_q[UP_W+SW-1:SW];
        assign b_up = g_st[k-1].g_up.b_q[UP_W+SW-1:SW];
      end

      // Skew registers: operand slices not yet added travel with the result.
      always_ff @(posedge clk) begin
        if (rdy[k]) begin
          a_q <= a_up;
          b_q <= b_up;
        end
      end
    end

    if (k == LAST) begin : g_fin
      logic ovf_q;
      logic zero_q;
      logic ovf_d;
      logic zero_d;

      // Carry into the MSB is a^b^sum at that bit; overflow when it differs
      // from the carry out.
      assign ovf_d  = (a_sl[SW-1] ^ b_sl[SW-1] ^ s_sl[SW-1]) ^ c_sl;
      assign zero_d = (sum_d == '0);

      // Status flags registered together with the final sum.
      always_ff @(posedge clk) begin
        if (rdy[k]) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  // Result fields read zero whenever no result is presented.
  assign Z    = vld_p[LAST] ? g_st[LAST].sum_q       : '0;
  assign cout = vld_p[LAST] & g_st[LAST].carry_q;
  assign ovf  = vld_p[LAST] & g_st[LAST].g_fin.ovf_q;
  assign zero = vld_p[LAST] & g_st[LAST].g_fin.zero_q;

endmodule : add_sub_pipe

// File: tb/tb_add_sub_pipe.sv
// Directed-vector bench for add_sub_pipe (WIDTH = 32, STAGES = 4).
module tb_add_sub_pipe;
  import add_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  add_sub_pipe #(
    .WIDTH (32),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Issue one operation with an idle pipeline and check latency and result.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [31:0] ez, input logic ec,
                        input logic eo, input logic ezr);
    int lat;
    A = a; B = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " Z"},       64'(Z),    64'(ez));
    chk({tag, " cout"},    64'(cout), 64'(ec));
    chk({tag, " ovf"},     64'(ovf),  64'(eo));
    chk({tag, " zero"},    64'(zero), 64'(ezr));
    @(posedge clk); #1;
    chk({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  // Stream vectors; flags packed as {cout, ovf, zero}.
  logic [31:0] sa [8] = '{32'h00000010, 32'h00000100, 32'h12345678, 32'h00000000,
                          32'hFFFFFFFE, 32'h40000000, 32'h0F0F0F0F, 32'hDEADBEEF};
  logic [31:0] sb [8] = '{32'h00000020, 32'h00000001, 32'h11111111, 32'h00000001,
                          32'h00000003, 32'hC0000000, 32'hF0F0F0F0, 32'hDEADBEEF};
  logic        so [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] sz [8] = '{32'h00000030, 32'h000000FF, 32'h23456789, 32'hFFFFFFFF,
                          32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
  logic [2:0]  sf [8] = '{3'b000, 3'b100, 3'b000, 3'b000,
                          3'b100, 3'b010, 3'b000, 3'b101};

  initial begin
    int ai;
    int oi;
    int lowc;
    int ghost;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op = OP_ADD;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset Z",         64'(Z),         64'd0);
    chk("reset flags",     64'({cout, ovf, zero}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add 1+2",        32'h00000001, 32'h00000002, OP_ADD, 32'h00000003, 1'b0, 1'b0, 1'b0);
    run_op("add ffffffff+1", 32'hFFFFFFFF, 32'h00000001, OP_ADD, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add 7fffffff+1", 32'h7FFFFFFF, 32'h00000001, OP_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("sub 80000000-1", 32'h80000000, 32'h00000001, OP_SUB, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub 5-7",        32'h00000005, 32'h00000007, OP_SUB, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub 9-9",        32'h00000009, 32'h00000009, OP_SUB, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("add ffff+1",     32'h0000FFFF, 32'h00000001, OP_ADD, 32'h00010000, 1'b0, 1'b0, 1'b0);
    run_op("add min+min",    32'h80000000, 32'h80000000, OP_ADD, 32'h00000000, 1'b1, 1'b1, 1'b1);

    // Back-to-back stream with the consumer stalled in cycles 5-7.
    ai = 0; oi = 0; lowc = 0;
    for (int cyc = 1; cyc <= 40 && oi < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (ai < 8) begin
        in_valid = 1'b1; A = sa[ai]; B = sb[ai]; op = so[ai];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) lowc++;
      if (out_valid) begin
        chk($sformatf("stream[%0d] cyc %0d", oi, cyc),
            64'({cout, ovf, zero, Z}), 64'({sf[oi], sz[oi]}));
        if (out_ready) oi++;
      end
      if (in_valid && in_ready) ai++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream results", 64'(oi), 64'd8);
    chk("stream in_ready low cycles", 64'(lowc), 64'd3);
    @(posedge clk); #1;
    chk("stream drained", 64'(out_valid), 64'd0);

    // Three operations in flight, then reset.
    for (int i = 0; i < 3; i++) begin
      A = 32'(i + 1); B = 32'h00000010; op = OP_ADD; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset in_ready",  64'(in_ready),  64'd1);
    chk("mid reset Z",         64'(Z),         64'd0);
    ghost = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) ghost++;
    end
    chk("no ops after reset", 64'(ghost), 64'd0);
    run_op("post-reset add", 32'h00000064, 32'h000000C8, OP_ADD, 32'h0000012C, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_add_sub_pipe

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, pipeline depth; each stage SHALL add one WIDTH/STAGES-bit slice.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set present on A, B, op.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 A, B  input  WIDTH  operands.
REQ-008 op  input  1  0 = add (A+B), 1 = subtract (A-B).
REQ-009 out_valid  output  1  result fields valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 Z  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 ovf  output  1  signed two's-complement overflow.
REQ-014 zero  output  1  Z == 0.

Function
REQ-015 Subtract SHALL be A + ~B with carry-in 1; add SHALL use carry-in 0.
REQ-016 Stage k SHALL add slice k (LSB slice at stage 0) using the carry registered by stage k-1; unprocessed upper slices and completed lower sum slices SHALL travel in skew registers alongside.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no back-pressure.
REQ-019 Each stage holds one valid bit; a stage SHALL advance when the next stage is empty or advancing; the last stage advances on out_ready or when empty.
REQ-020 in_ready SHALL equal "stage 0 empty or advancing"; combinational path from out_ready to in_ready is permitted.
REQ-021 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-022 While out_valid && !out_ready, Z/cout/ovf/zero SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order; no loss, no duplication, under any valid/ready pattern.
REQ-024 ovf SHALL equal carry into MSB XOR carry out of MSB; zero SHALL be computed in the final stage.
REQ-025 Data registers of empty stages are don't-care; only valid bits need reset.
REQ-026 in_valid with in_ready low SHALL NOT change state; the source must hold A, B, op.

Reset
REQ-027 reset high at a clock edge SHALL clear all stage valid bits; next cycle out_valid = 0, in_ready = 1.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none may emerge after reset.
REQ-029 Z, cout, ovf, zero SHALL read 0 after reset until the first valid result.

Structure
REQ-030 Shared package add_pkg SHALL hold the op encodings OP_ADD = 0, OP_SUB = 1.
REQ-031 One sub-module, adder_slice (parametrised width, combinational ripple of 1-bit full adders, ports sum, cout, a, b, cin), SHALL be instantiated once per stage.
REQ-032 WIDTH % STAGES != 0 SHALL be rejected at elaboration.

Verification (WIDTH = 32, STAGES = 4)
REQ-033 add 0x00000001 + 0x00000002 -> Z = 0x00000003, cout/ovf/zero = 0, out_valid exactly 4 cycles after accept.
REQ-034 add 0xFFFFFFFF + 0x00000001 -> Z = 0, cout = 1, zero = 1, ovf = 0 (carry crosses all slices).
REQ-035 add 0x7FFFFFFF + 1 -> Z = 0x80000000, ovf = 1; sub 0x80000000 - 1 -> Z = 0x7FFFFFFF, ovf = 1, cout = 1.
REQ-036 sub 5 - 7 -> Z = 0xFFFFFFFE, cout = 0, ovf = 0; sub 9 - 9 -> Z = 0, zero = 1, cout = 1.
REQ-037 Stream 8 ops back-to-back with out_ready low for cycles 5-7 -> in_ready drops once full, all 8 results correct, in order, held stable while stalled.
REQ-038 reset asserted with 3 ops in flight -> out_valid 0 next cycle; none of the 3 ever appears; a fresh op afterwards completes in 4 cycles.
